// File: rtl/act_relu_quant.sv
// -----------------------------------------------------------------------------
// act_relu_quant
//
// Per-lane activation stage placed in front of the pooling lanes. Signed
// partial sums from the PE array get a per-layer bias added, are requantised
// by a round-half-up arithmetic right shift, pass through ReLU, and are
// saturated to an unsigned DATA_WIDTH result. Each accepted partial sum
// produces exactly one activation, exactly three cycles later, tagged with
// a sequential output address.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous reset, active high
//   cfg_valid_i           load bias/shift/base address (honoured only when idle)
//   cfg_bias_i            signed per-layer bias
//   cfg_shift_i           requantisation right-shift amount
//   cfg_base_addr_i       address given to the first activation of the tile
//   psum_valid_i          partial sum valid (no backpressure)
//   psum_i                signed partial sum
//   psum_last_i           marks the final partial sum of the tile
//   busy_o                high while a tile is running or draining
//   done_o                one-cycle pulse when the tile has fully drained
//   act_valid_o           activation valid
//   act_last_o            final activation of the tile (qualified by act_valid_o)
//   act_result_o          activation value
//   act_result_address_o  activation address
// -----------------------------------------------------------------------------
module act_relu_quant #(
   parameter int ACC_WIDTH     = 20,
   parameter int BIAS_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 10,
   parameter int SHIFT_WIDTH   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid_i,
   input  logic [BIAS_WIDTH-1:0]    cfg_bias_i,
   input  logic [SHIFT_WIDTH-1:0]   cfg_shift_i,
   input  logic [ADDRESS_WIDTH-1:0] cfg_base_addr_i,
   input  logic                     psum_valid_i,
   input  logic [ACC_WIDTH-1:0]     psum_i,
   input  logic                     psum_last_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     act_valid_o,
   output logic                     act_last_o,
   output logic [DATA_WIDTH-1:0]    act_result_o,
   output logic [ADDRESS_WIDTH-1:0] act_result_address_o
);

   // Bias addition cannot overflow at one bit wider than the wider operand;
   // the rounding add needs one further bit.
   localparam int SUM_WIDTH = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
   localparam int RND_WIDTH = SUM_WIDTH + 1;
   localparam logic signed [RND_WIDTH-1:0] SAT_MAX = RND_WIDTH'((2 ** DATA_WIDTH) - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Control / configuration
   state_t                     state_q, state_d;
   logic [BIAS_WIDTH-1:0]      bias_q, bias_d;
   logic [SHIFT_WIDTH-1:0]     shift_q, shift_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic                       done_q, done_d;
   logic                       accept;

   // Capture register: the accepted element and its address
   logic                       p0_valid_q;
   logic [ACC_WIDTH-1:0]       p0_psum_q;
   logic [ADDRESS_WIDTH-1:0]   p0_addr_q;
   logic                       p0_last_q;

   // Stage 1: biased sum
   logic                       s1_valid_q;
   logic signed [SUM_WIDTH-1:0] s1_sum_q, s1_sum_d;
   logic [ADDRESS_WIDTH-1:0]   s1_addr_q;
   logic                       s1_last_q;
   logic signed [SUM_WIDTH-1:0] psum_ext, bias_ext;

   // Stage 2: rounded, shifted value
   logic                       s2_valid_q;
   logic signed [RND_WIDTH-1:0] s2_r_q, s2_r_d;
   logic [ADDRESS_WIDTH-1:0]   s2_addr_q;
   logic                       s2_last_q;
   logic signed [RND_WIDTH-1:0] s2_ext, s2_rnd;

   // Stage 3: ReLU + saturation, drives the output stream
   logic                       act_valid_q;
   logic                       act_last_q;
   logic [DATA_WIDTH-1:0]      act_result_q, act_result_d;
   logic [ADDRESS_WIDTH-1:0]   act_addr_q;

   // ---------------------------------------------------------------------------
   // Control FSM: next state, config loads and address counter
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      bias_d  = bias_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid_i) begin
               bias_d  = cfg_bias_i;
               shift_d = cfg_shift_i;
               addr_d  = cfg_base_addr_i;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (psum_valid_i) begin
               accept = 1'b1;
               addr_d = addr_q + ADDRESS_WIDTH'(1);
               if (psum_last_i) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The last element is on the output this cycle, so the pipeline
            // is empty after this edge.
            if (act_valid_q && act_last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath combinational logic
   // ---------------------------------------------------------------------------
   always_comb begin
      psum_ext = $signed({{(SUM_WIDTH - ACC_WIDTH){p0_psum_q[ACC_WIDTH-1]}}, p0_psum_q});
      bias_ext = $signed({{(SUM_WIDTH - BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q});
      s1_sum_d = psum_ext + bias_ext;
   end

   // Round half up: add half an LSB of the shifted result, then floor via >>>.
   always_comb begin
      s2_ext = $signed({s1_sum_q[SUM_WIDTH-1], s1_sum_q});
      s2_rnd = '0;
      if (shift_q != '0) begin
         s2_rnd = RND_WIDTH'(1) << (shift_q - SHIFT_WIDTH'(1));
      end
      s2_r_d = (s2_ext + s2_rnd) >>> shift_q;
   end

   always_comb begin
      if (s2_r_q[RND_WIDTH-1]) begin
         act_result_d = '0;
      end else if (s2_r_q > SAT_MAX) begin
         act_result_d = '1;
      end else begin
         act_result_d = s2_r_q[DATA_WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         bias_q  <= '0;
         shift_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bias_q  <= bias_d;
         shift_q <= shift_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // Valids always advance; payload registers only load alongside a valid so
   // the output payload holds its last value between activations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_valid_q   <= 1'b0;
         p0_psum_q    <= '0;
         p0_addr_q    <= '0;
         p0_last_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_sum_q     <= '0;
         s1_addr_q    <= '0;
         s1_last_q    <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_r_q       <= '0;
         s2_addr_q    <= '0;
         s2_last_q    <= 1'b0;
         act_valid_q  <= 1'b0;
         act_result_q <= '0;
         act_addr_q   <= '0;
         act_last_q   <= 1'b0;
      end else begin
         p0_valid_q  <= accept;
         s1_valid_q  <= p0_valid_q;
         s2_valid_q  <= s1_valid_q;
         act_valid_q <= s2_valid_q;
         if (accept) begin
            p0_psum_q <= psum_i;
            p0_addr_q <= addr_q;
            p0_last_q <= psum_last_i;
         end
         if (p0_valid_q) begin
            s1_sum_q  <= s1_sum_d;
            s1_addr_q <= p0_addr_q;
            s1_last_q <= p0_last_q;
         end
         if (s1_valid_q) begin
            s2_r_q    <= s2_r_d;
            s2_addr_q <= s1_addr_q;
            s2_last_q <= s1_last_q;
         end
         if (s2_valid_q) begin
            act_result_q <= act_result_d;
            act_addr_q   <= s2_addr_q;
            act_last_q   <= s2_last_q;
         end
      end
   end

   assign busy_o               = (state_q != ST_IDLE);
   assign done_o               = done_q;
   assign act_valid_o          = act_valid_q;
   assign act_last_o           = act_last_q;
   assign act_result_o         = act_result_q;
   assign act_result_address_o = act_addr_q;

endmodule

// File: tb/tb_act_relu_quant.sv
// -----------------------------------------------------------------------------
// Self-checking bench for act_relu_quant: table-driven vectors, hand-written
// latency / ignored-input / reset sequences, and randomized tiles checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_act_relu_quant;

   localparam int ACC_WIDTH     = 20;
   localparam int BIAS_WIDTH    = 16;
   localparam int DATA_WIDTH    = 8;
   localparam int ADDRESS_WIDTH = 10;
   localparam int SHIFT_WIDTH   = 5;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     cfg_valid_i;
   logic [BIAS_WIDTH-1:0]    cfg_bias_i;
   logic [SHIFT_WIDTH-1:0]   cfg_shift_i;
   logic [ADDRESS_WIDTH-1:0] cfg_base_addr_i;
   logic                     psum_valid_i;
   logic [ACC_WIDTH-1:0]     psum_i;
   logic                     psum_last_i;
   logic                     busy_o;
   logic                     done_o;
   logic                     act_valid_o;
   logic                     act_last_o;
   logic [DATA_WIDTH-1:0]    act_result_o;
   logic [ADDRESS_WIDTH-1:0] act_result_address_o;

   act_relu_quant #(
      .ACC_WIDTH    (ACC_WIDTH),
      .BIAS_WIDTH   (BIAS_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .SHIFT_WIDTH  (SHIFT_WIDTH)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .cfg_valid_i         (cfg_valid_i),
      .cfg_bias_i          (cfg_bias_i),
      .cfg_shift_i         (cfg_shift_i),
      .cfg_base_addr_i     (cfg_base_addr_i),
      .psum_valid_i        (psum_valid_i),
      .psum_i              (psum_i),
      .psum_last_i         (psum_last_i),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .act_valid_o         (act_valid_o),
      .act_last_o          (act_last_o),
      .act_result_o        (act_result_o),
      .act_result_address_o(act_result_address_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit new_cfg;
      int bias;
      int shift;
      int base;
      int psum;
      bit last;
      int exp_res;
      int exp_addr;
   } vec_t;

   typedef struct {
      int res;
      int addr;
      bit last;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   exp_t mon_e;

   int checks   = 0;
   int failures = 0;
   int n_valid  = 0;

   int m_bias;
   int m_shift;
   int m_addr;

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Reference: exact integer arithmetic, floor division for the shift.
   function automatic int model_act(input int psum, input int bias, input int shift);
      longint s, d, n, r;
      s = longint'(psum) + longint'(bias);
      if (shift == 0) begin
         r = s;
      end else begin
         d = longint'(1) << shift;
         n = s + d / 2;
         r = n / d;
         if ((n % d != 0) && (n < 0)) r = r - 1;
      end
      if (r < 0) return 0;
      if (r > 255) return 255;
      return int'(r);
   endfunction

   function automatic void add_vec(input bit nc, input int b, input int s, input int base,
                                   input int p, input bit l, input int er, input int ea);
      vec_t v;
      v = '{nc, b, s, base, p, l, er, ea};
      vecs.push_back(v);
   endfunction

   // Output monitor: every valid activation must match the next expected one.
   always @(negedge clk) begin
      if (!rst && act_valid_o) begin
         n_valid++;
         check("expected_pending", longint'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("act_result", act_result_o, mon_e.res);
            check("act_address", act_result_address_o, mon_e.addr);
            check("act_last", act_last_o, mon_e.last);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input int bias, input int shift, input int base);
      cfg_valid_i     = 1'b1;
      cfg_bias_i      = BIAS_WIDTH'(bias);
      cfg_shift_i     = SHIFT_WIDTH'(shift);
      cfg_base_addr_i = ADDRESS_WIDTH'(base);
      cycle();
      cfg_valid_i = 1'b0;
      m_bias  = bias;
      m_shift = shift;
      m_addr  = base;
   endtask

   task automatic send_psum(input int psum, input bit last, input int exp_res, input int exp_addr);
      exp_t e;
      psum_valid_i = 1'b1;
      psum_i       = ACC_WIDTH'(psum);
      psum_last_i  = last;
      cycle();
      psum_valid_i = 1'b0;
      psum_last_i  = 1'b0;
      e = '{exp_res, exp_addr, last};
      exp_q.push_back(e);
      m_addr = (m_addr + 1) % 1024;
   endtask

   task automatic wait_done(input string tag);
      int last_c = -1;
      int done_c = -1;
      int n_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (act_valid_o && act_last_o && last_c < 0) begin
            last_c = c;
            check({tag, "_busy_at_last"}, busy_o, 1);
         end
         if (done_o) begin
            n_done++;
            if (done_c < 0) done_c = c;
            check({tag, "_busy_at_done"}, busy_o, 0);
         end
         if (done_c >= 0 && c >= done_c + 3) break;
      end
      check({tag, "_done_count"}, n_done, 1);
      check({tag, "_done_after_last"}, done_c - last_c, 1);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int nv;
      rst             = 1'b1;
      cfg_valid_i     = 1'b0;
      cfg_bias_i      = '0;
      cfg_shift_i     = '0;
      cfg_base_addr_i = '0;
      psum_valid_i    = 1'b0;
      psum_i          = '0;
      psum_last_i     = 1'b0;
      m_bias = 0; m_shift = 0; m_addr = 0;

      // Reset state
      repeat (3) cycle();
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_valid", act_valid_o, 0);
      check("rst_last", act_last_o, 0);
      check("rst_result", act_result_o, 0);
      check("rst_addr", act_result_address_o, 0);
      rst = 1'b0;
      cycle();

      // Table vectors: {new_cfg, bias, shift, base, psum, last, exp_res, exp_addr}
      add_vec(1, 0, 0, 0,    5,    0, 5,   0);
      add_vec(0, 0, 0, 0,   -3,    0, 0,   1);
      add_vec(0, 0, 0, 0,  300,    1, 255, 2);
      add_vec(1, 2, 2, 32,   6,    0, 2,   32);
      add_vec(0, 0, 0, 0,    5,    0, 2,   33);
      add_vec(0, 0, 0, 0,   -7,    1, 0,   34);
      add_vec(1, 0, 0, 1022, 1,    0, 1,   1022);
      add_vec(0, 0, 0, 0,    2,    0, 2,   1023);
      add_vec(0, 0, 0, 0,    3,    0, 3,   0);
      add_vec(0, 0, 0, 0,    4,    1, 4,   1);
      add_vec(1, -100, 1, 5, 611,  0, 255, 5);
      add_vec(0, 0, 0, 0,  610,    0, 255, 6);
      add_vec(0, 0, 0, 0,  100,    0, 0,   7);
      add_vec(0, 0, 0, 0,   99,    0, 0,   8);
      add_vec(0, 0, 0, 0,  103,    1, 2,   9);
      add_vec(1, 32767, 20, 256, 524287, 0, 1, 256);
      add_vec(0, 0, 0, 0, -524288, 0, 0, 257);
      add_vec(0, 0, 0, 0,  491521, 0, 1, 258);
      add_vec(0, 0, 0, 0,  491520, 1, 0, 259);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].new_cfg) do_cfg(vecs[i].bias, vecs[i].shift, vecs[i].base);
         send_psum(vecs[i].psum, vecs[i].last, vecs[i].exp_res, vecs[i].exp_addr);
         if (vecs[i].last) wait_done("tbl");
      end

      // Latency: accepted at edge N, valid after edge N+3, done after N+4
      do_cfg(0, 0, 16);
      send_psum(10, 1'b1, 10, 16);
      for (int k = 1; k <= 3; k++) begin
         cycle();
         if (k < 3) begin
            check("lat_no_valid_early", act_valid_o, 0);
         end else begin
            check("lat_valid", act_valid_o, 1);
            check("lat_value", act_result_o, 10);
            check("lat_addr", act_result_address_o, 16);
            check("lat_busy_at_last", busy_o, 1);
         end
      end
      cycle();
      check("lat_done_pulse", done_o, 1);
      check("lat_busy_fall", busy_o, 0);
      cycle();
      check("lat_done_single", done_o, 0);

      // psum in IDLE is dropped
      nv = n_valid;
      for (int k = 0; k < 4; k++) begin
         psum_valid_i = 1'b1;
         psum_i       = ACC_WIDTH'(77);
         psum_last_i  = k[0];
         cycle();
      end
      psum_valid_i = 1'b0;
      psum_last_i  = 1'b0;
      repeat (6) cycle();
      check("idle_psum_no_output", n_valid - nv, 0);
      check("idle_psum_not_busy", busy_o, 0);

      // cfg in RUN and DRAIN is ignored
      do_cfg(0, 0, 64);
      send_psum(7, 1'b0, 7, 64);
      cfg_valid_i = 1'b1; cfg_bias_i = BIAS_WIDTH'(100);
      cfg_shift_i = SHIFT_WIDTH'(3); cfg_base_addr_i = ADDRESS_WIDTH'(512);
      cycle();
      cfg_valid_i = 1'b0;
      send_psum(9, 1'b1, 9, 65);
      cfg_valid_i = 1'b1; psum_valid_i = 1'b1; psum_i = ACC_WIDTH'(50);
      cycle();
      cfg_valid_i = 1'b0; psum_valid_i = 1'b0;
      wait_done("cfg_ignored");

      // Reset mid-stream: two psums accepted, reset one cycle later
      do_cfg(0, 0, 128);
      send_psum(5, 1'b0, 5, 128);
      send_psum(6, 1'b0, 6, 129);
      cycle();
      rst = 1'b1;
      #1;
      check("midrst_busy", busy_o, 0);
      check("midrst_valid", act_valid_o, 0);
      check("midrst_result", act_result_o, 0);
      check("midrst_addr", act_result_address_o, 0);
      exp_q.delete();
      nv = n_valid;
      cycle();
      rst = 1'b0;
      repeat (6) cycle();
      check("midrst_no_output", n_valid - nv, 0);
      check("midrst_idle", busy_o, 0);
      check("midrst_done", done_o, 0);

      // Randomized tiles against the reference model
      for (int g = 0; g < 12; g++) begin
         int bias, shift, base, n, p;
         logic [19:0] r20;
         bias  = int'($urandom_range(0, 65535)) - 32768;
         shift = (g % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
         base  = int'($urandom_range(0, 1023));
         n     = int'($urandom_range(3, 30));
         do_cfg(bias, shift, base);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               psum_valid_i = 1'b0;
               psum_last_i  = 1'($urandom_range(0, 1));
               psum_i       = ACC_WIDTH'($urandom);
               cycle();
               psum_last_i  = 1'b0;
            end
            if (g % 2 == 0) begin
               p = int'($urandom_range(0, 600 << shift)) - (100 << shift) - bias;
               if (p > 524287) p = 524287;
               if (p < -524288) p = -524288;
            end else begin
               r20 = 20'($urandom);
               p   = int'($signed(r20));
            end
            send_psum(p, k == n - 1, model_act(p, m_bias, m_shift), m_addr);
         end
         wait_done("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
